// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode constants, default widths, fetch states and
// the opcode-field extractor used by the ROM, decoder and fetch sequencer.
package cpu_isa_pkg;

  localparam int unsigned DEF_PC_W   = 16;
  localparam int unsigned DEF_INST_W = 9;
  localparam int unsigned OP_W       = 5;

  localparam logic [OP_W-1:0] OP_ADD         = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB         = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND         = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR          = 5'b00011;
  localparam logic [OP_W-1:0] OP_SHL         = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR         = 5'b00101;
  localparam logic [OP_W-1:0] OP_SETI        = 5'b00110;
  localparam logic [OP_W-1:0] OP_LOAD        = 5'b00111;
  localparam logic [OP_W-1:0] OP_STORE       = 5'b01000;
  localparam logic [OP_W-1:0] OP_BEQ         = 5'b01001;
  localparam logic [OP_W-1:0] OP_JMP         = 5'b01010;
  localparam logic [OP_W-1:0] OP_MATH_TO_ADR = 5'b01011;
  localparam logic [OP_W-1:0] OP_HALT        = 5'b11010;

  typedef enum logic [1:0] {
    FETCH_RUN       = 2'd0,
    FETCH_HALT_PEND = 2'd1,
    FETCH_HALTED    = 2'd2
  } fetch_state_e;

  function automatic logic [OP_W-1:0] opcode_of(input logic [DEF_INST_W-1:0] inst);
    return inst[DEF_INST_W-1 -: OP_W];
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Saturating fetch/bubble event counters; instantiated by fetch_sequencer
// only when FETCH_PERF_CNT_EN is defined.
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_event,
  input  logic        bubble_event,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (fetch_event && (fetch_count != 32'hFFFF_FFFF))
        fetch_count <= fetch_count + 32'd1;
      if (bubble_event && (bubble_count != 32'hFFFF_FFFF))
        bubble_count <= bubble_count + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: PC, IF/ID register, stall/redirect handling and
// drained halt sequencing. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_sequencer
  import cpu_isa_pkg::*;
#(
  parameter int unsigned     PC_W         = DEF_PC_W,
  parameter int unsigned     INST_W       = DEF_INST_W,
  parameter logic [PC_W-1:0] RESET_PC     = PC_W'(1),
  parameter logic [4:0]      HALT_OPCODE  = OP_HALT,
  parameter int unsigned     DRAIN_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_target,
  output logic [PC_W-1:0]   pc,
  input  logic [INST_W-1:0] rom_instruction,
  output logic [INST_W-1:0] if_instruction,
  output logic [PC_W-1:0]   if_pc,
  output logic              if_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       bubble_count
`endif
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] RUN       = FETCH_RUN;
  localparam logic [1:0] HALT_PEND = FETCH_HALT_PEND;
  localparam logic [1:0] HALTED    = FETCH_HALTED;

  logic [1:0]        state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [PC_W-1:0]   pc_nx, if_pc_nx;
  logic [INST_W-1:0] if_inst_nx;
  logic              if_valid_nx;
  logic              is_halt;

  assign is_halt = (rom_instruction[INST_W-1 -: 5] == HALT_OPCODE);

  // State and IF/ID registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= RUN;
      cnt            <= '0;
      pc             <= RESET_PC;
      if_instruction <= '0;
      if_pc          <= '0;
      if_valid       <= 1'b0;
      halted         <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      pc             <= pc_nx;
      if_instruction <= if_inst_nx;
      if_pc          <= if_pc_nx;
      if_valid       <= if_valid_nx;
      halted         <= (state == HALTED);
    end
  end

  // Next-state logic: redirect beats stall beats normal fetch
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    pc_nx       = pc;
    if_inst_nx  = if_instruction;
    if_pc_nx    = if_pc;
    if_valid_nx = if_valid;
    case (state)
      RUN: begin
        if (redirect_valid) begin
          pc_nx       = redirect_target;
          if_valid_nx = 1'b0;
          if_inst_nx  = '0;
        end else if (!stall) begin
          if_inst_nx  = rom_instruction;
          if_pc_nx    = pc;
          if_valid_nx = 1'b1;
          if (is_halt) begin
            state_nx = HALT_PEND;
            cnt_nx   = CNT_W'(DRAIN_CYCLES);
          end else begin
            pc_nx = pc + PC_W'(1);
          end
        end
      end
      HALT_PEND: begin
        // An older redirect squashes the speculatively fetched halt
        if (redirect_valid) begin
          pc_nx       = redirect_target;
          if_valid_nx = 1'b0;
          if_inst_nx  = '0;
          state_nx    = RUN;
          cnt_nx      = '0;
        end else if (!stall) begin
          if_valid_nx = 1'b0;
          if (cnt <= CNT_W'(1)) begin
            cnt_nx   = '0;
            state_nx = HALTED;
          end else begin
            cnt_nx = cnt - CNT_W'(1);
          end
        end
      end
      HALTED: begin
        if_valid_nx = 1'b0;
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

`ifdef FETCH_PERF_CNT_EN
  logic fetch_event_c, bubble_event_c;

  assign fetch_event_c  = (state == RUN) && !redirect_valid && !stall;
  assign bubble_event_c = (state != HALTED) && !fetch_event_c;

  fetch_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_event  (fetch_event_c),
    .bubble_event (bubble_event_c),
    .fetch_count  (fetch_count),
    .bubble_count (bubble_count)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer (default build).
module tb_fetch_sequencer;
  import cpu_isa_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] pc;
  logic [8:0]  rom_instruction;
  logic [8:0]  if_instruction;
  logic [15:0] if_pc;
  logic        if_valid;
  logic        halted;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .rom_instruction (rom_instruction),
    .if_instruction  (if_instruction),
    .if_pc           (if_pc),
    .if_valid        (if_valid),
    .halted          (halted)
  );

  localparam logic [8:0] W_SETI1 = 9'b00110_0001;
  localparam logic [8:0] W_MTA   = {OP_MATH_TO_ADR, 4'b0000};
  localparam logic [8:0] W_HALT  = {OP_HALT, 4'b0000};

  // Program: 1 seti 1, 2 mathToAdr 0, 14 halt, everything else add <low nibble>
  function automatic logic [8:0] rom_word(input logic [15:0] a);
    if (a == 16'd1)  return W_SETI1;
    if (a == 16'd2)  return W_MTA;
    if (a == 16'd14) return W_HALT;
    return {OP_ADD, a[3:0]};
  endfunction

  always_comb rom_instruction = rom_word(pc);

  typedef struct {
    logic        s;
    logic        rv;
    logic [15:0] tgt;
    logic [15:0] e_pc;
    logic        e_v;
    logic [15:0] e_ifpc;
    logic        chk_inst;
    logic [8:0]  e_inst;
    logic        e_h;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic rv, input logic [15:0] tgt,
                              input logic [15:0] p, input logic v, input logic [15:0] ip,
                              input logic ci, input logic [8:0] ins, input logic h);
    vec_t r;
    r.s = s; r.rv = rv; r.tgt = tgt; r.e_pc = p; r.e_v = v; r.e_ifpc = ip;
    r.chk_inst = ci; r.e_inst = ins; r.e_h = h;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic rv, input logic [15:0] tgt);
    stall = s;
    redirect_valid = rv;
    redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'd1);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_inst", 32'(if_instruction), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t vecs[25];

  initial begin
    vecs[0]  = mk(0, 0, 16'd0,  16'd2,  1, 16'd1,  1, W_SETI1, 0);
    vecs[1]  = mk(0, 0, 16'd0,  16'd3,  1, 16'd2,  1, W_MTA, 0);
    vecs[2]  = mk(0, 0, 16'd0,  16'd4,  1, 16'd3,  1, rom_word(16'd3), 0);
    vecs[3]  = mk(0, 0, 16'd0,  16'd5,  1, 16'd4,  1, rom_word(16'd4), 0);
    vecs[4]  = mk(0, 0, 16'd0,  16'd6,  1, 16'd5,  1, rom_word(16'd5), 0);
    vecs[5]  = mk(0, 0, 16'd0,  16'd7,  1, 16'd6,  1, rom_word(16'd6), 0);
    vecs[6]  = mk(0, 0, 16'd0,  16'd8,  1, 16'd7,  1, rom_word(16'd7), 0);
    vecs[7]  = mk(0, 1, 16'd2,  16'd2,  0, 16'd0,  1, 9'd0, 0);
    vecs[8]  = mk(0, 0, 16'd0,  16'd3,  1, 16'd2,  1, W_MTA, 0);
    vecs[9]  = mk(1, 1, 16'd9,  16'd9,  0, 16'd0,  1, 9'd0, 0);
    vecs[10] = mk(1, 0, 16'd0,  16'd9,  0, 16'd0,  1, 9'd0, 0);
    vecs[11] = mk(0, 0, 16'd0,  16'd10, 1, 16'd9,  1, rom_word(16'd9), 0);
    vecs[12] = mk(1, 0, 16'd0,  16'd10, 1, 16'd9,  1, rom_word(16'd9), 0);
    vecs[13] = mk(1, 0, 16'd0,  16'd10, 1, 16'd9,  1, rom_word(16'd9), 0);
    vecs[14] = mk(0, 0, 16'd0,  16'd11, 1, 16'd10, 1, rom_word(16'd10), 0);
    vecs[15] = mk(0, 0, 16'd0,  16'd12, 1, 16'd11, 1, rom_word(16'd11), 0);
    vecs[16] = mk(0, 0, 16'd0,  16'd13, 1, 16'd12, 1, rom_word(16'd12), 0);
    vecs[17] = mk(0, 0, 16'd0,  16'd14, 1, 16'd13, 1, rom_word(16'd13), 0);
    vecs[18] = mk(0, 0, 16'd0,  16'd14, 1, 16'd14, 1, W_HALT, 0);
    vecs[19] = mk(0, 0, 16'd0,  16'd14, 0, 16'd0,  0, 9'd0, 0);
    vecs[20] = mk(0, 0, 16'd0,  16'd14, 0, 16'd0,  0, 9'd0, 0);
    vecs[21] = mk(0, 0, 16'd0,  16'd14, 0, 16'd0,  0, 9'd0, 0);
    vecs[22] = mk(0, 0, 16'd0,  16'd14, 0, 16'd0,  0, 9'd0, 1);
    vecs[23] = mk(1, 1, 16'd5,  16'd14, 0, 16'd0,  0, 9'd0, 1);
    vecs[24] = mk(0, 1, 16'd5,  16'd14, 0, 16'd0,  0, 9'd0, 1);

    // Table: fetch, redirect, stall, halt drain
    do_reset();
    for (int i = 0; i < 25; i++) begin
      step(vecs[i].s, vecs[i].rv, vecs[i].tgt);
      chk($sformatf("v%0d_pc", i), 32'(pc), 32'(vecs[i].e_pc));
      chk($sformatf("v%0d_valid", i), 32'(if_valid), 32'(vecs[i].e_v));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vecs[i].e_h));
      if (vecs[i].e_v)
        chk($sformatf("v%0d_ifpc", i), 32'(if_pc), 32'(vecs[i].e_ifpc));
      if (vecs[i].chk_inst)
        chk($sformatf("v%0d_inst", i), 32'(if_instruction), 32'(vecs[i].e_inst));
    end

    // Halt squashed by a redirect one cycle after the halt fetch
    do_reset();
    step(0, 1, 16'd14);
    chk("sq_pc14", 32'(pc), 32'd14);
    step(0, 0, 16'd0);
    chk("sq_halt_valid", 32'(if_valid), 32'd1);
    chk("sq_halt_inst", 32'(if_instruction), 32'(W_HALT));
    step(0, 1, 16'd5);
    chk("sq_redir_pc", 32'(pc), 32'd5);
    chk("sq_redir_valid", 32'(if_valid), 32'd0);
    step(0, 0, 16'd0);
    chk("sq_ifpc5", 32'(if_pc), 32'd5);
    chk("sq_valid5", 32'(if_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 16'd0);
      chk($sformatf("sq_nohalt%0d", k), 32'(halted), 32'd0);
      chk($sformatf("sq_pc%0d", k), 32'(pc), 32'(7 + k));
    end

    // Stall freezes the drain counter; redirect on the would-be-final edge wins
    step(0, 1, 16'd14);
    step(0, 0, 16'd0);
    chk("dr_capture", 32'(if_pc), 32'd14);
    step(0, 0, 16'd0);
    step(1, 0, 16'd0);
    chk("dr_stall_valid", 32'(if_valid), 32'd0);
    step(0, 0, 16'd0);
    step(0, 1, 16'd5);
    chk("dr_redir_pc", 32'(pc), 32'd5);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 16'd0);
      chk($sformatf("dr_nohalt%0d", k), 32'(halted), 32'd0);
      chk($sformatf("dr_ifpc%0d", k), 32'(if_pc), 32'(5 + k));
    end

    // PC wrap at 16'hFFFF, then async reset in HALT_PEND
    do_reset();
    step(0, 1, 16'hFFFF);
    chk("wr_pc_ffff", 32'(pc), 32'hFFFF);
    step(0, 0, 16'd0);
    chk("wr_ifpc", 32'(if_pc), 32'hFFFF);
    chk("wr_inst", 32'(if_instruction), 32'(rom_word(16'hFFFF)));
    chk("wr_pc0", 32'(pc), 32'd0);
    step(0, 0, 16'd0);
    chk("wr_pc1", 32'(pc), 32'd1);
    chk("wr_ifpc0", 32'(if_pc), 32'd0);
    step(0, 1, 16'd14);
    step(0, 0, 16'd0);
    step(0, 0, 16'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pc", 32'(pc), 32'd1);
    chk("ar_valid", 32'(if_valid), 32'd0);
    chk("ar_halted", 32'(halted), 32'd0);
    chk("ar_ifpc", 32'(if_pc), 32'd0);
    chk("ar_inst", 32'(if_instruction), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 16'd0);
    chk("ar_resume_pc", 32'(pc), 32'd2);
    chk("ar_resume_inst", 32'(if_instruction), 32'(W_SETI1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the 9-bit-instruction pipelined CPU. It owns the program counter, addresses the combinational instruction ROM, and registers the fetched word into the IF/ID pipeline register. It honours stalls from the hazard unit and redirects from the execute stage, and sequences processor halt. Halt uses a drain window, so a speculatively fetched halt behind an unresolved branch is squashed rather than committed.

Parameters:
PC_W, 16, program-counter and ROM address width
INST_W, 9, instruction width ({opcode[4:0], operand[3:0]})
RESET_PC, 16'd1, first fetch address after reset
HALT_OPCODE, 5'b11010, opcode that triggers halt sequencing
DRAIN_CYCLES, 3, non-stalled cycles to wait after a halt fetch for older redirects; range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  hazard unit: hold PC and IF/ID register
redirect_valid  in  1  execute stage: taken branch or jump
redirect_target  in  PC_W  new fetch address when redirect_valid=1
pc  out  PC_W  fetch address to the instruction ROM, registered
rom_instruction  in  INST_W  ROM data for pc, same cycle (combinational ROM)
if_instruction  out  INST_W  IF/ID instruction
if_pc  out  PC_W  IF/ID address of if_instruction
if_valid  out  1  IF/ID contents are a real instruction
halted  out  1  processor halted

Behaviour:
- Single clock domain. rst_n is asynchronous active-low and is fixed as such. Assertion, including mid-operation, forces: pc=RESET_PC, if_instruction=0, if_pc=0, if_valid=0, halted=0, state=RUN, drain counter=0.
- Latency: the word at pc appears on if_instruction/if_pc one edge later.
- Priority each edge: reset > redirect_valid > stall > normal.
- States: RUN, HALT_PEND, HALTED.
- RUN, redirect_valid=1 (overrides stall):
  - pc<=redirect_target, if_valid<=0, if_instruction<=0 (flush).
- RUN, stall=1, no redirect: all registers hold.
- RUN, normal, rom_instruction[8:4]!=HALT_OPCODE:
  - if_instruction<=rom_instruction, if_pc<=pc, if_valid<=1.
  - pc<=pc+1, modulo 2^PC_W, so 16'hFFFF wraps to 16'h0000.
- RUN, normal, rom_instruction[8:4]==HALT_OPCODE:
  - Capture the halt into IF/ID with if_valid<=1; pc holds.
  - State goes to HALT_PEND with counter<=DRAIN_CYCLES.
- HALT_PEND:
  - pc frozen; if_valid<=0 on non-stalled edges.
  - Counter decrements only on non-stalled edges.
  - redirect_valid=1: pc<=redirect_target, flush, state goes to RUN (halt squashed).
  - Counter reaches 0 with no redirect: state goes to HALTED.
  - A redirect in the same edge the counter would hit 0 wins.
- HALTED:
  - halted=1 (registered, asserts the edge after entry); pc frozen; if_valid=0.
  - stall and redirect_valid are ignored; only rst_n exits.
- Stall arriving in the same edge as a halt fetch: the halt is not detected until stall drops.
- redirect_target is consumed only when redirect_valid=1; its value is don't-care otherwise.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: adds outputs fetch_count[31:0] and bubble_count[31:0].
  - fetch_count increments on each edge with if_valid<=1.
  - bubble_count increments on each edge where if_valid<=0 and state!=HALTED (flush, stall, drain).
  - Both counters reset to 0, saturate at 32'hFFFFFFFF, and freeze in HALTED.
- Undefined: the ports and logic are absent; the remaining behaviour is identical.

Decomposition:
- Shared package cpu_isa_pkg holds the 5-bit opcode constants (add..halt) used by the ROM, decoder and this block, plus PC_W/INST_W defaults and the fetch state enum (RUN, HALT_PEND, HALTED).
- No sub-module needed for core fetch.
- Under FETCH_PERF_CNT_EN, the counters go in sub-module fetch_perf_counters.

Test Plan:
- Reset then release, ROM program at 1..14 -> pc=1 during reset; after first edge if_pc=1, if_instruction=9'b001100001 (seti 0001), if_valid=1, pc=2.
- Redirect_valid=1, target=16'd2, while pc=8 -> next edge pc=2, if_valid=0; following edge if_pc=2, if_instruction={mathToAdr,0000}.
- Run to pc=14 (halt), DRAIN_CYCLES=3, no redirect -> if_pc=14 valid once, then 3 bubbles, halted=1 one edge after the counter reaches 0; pc stays 14.
- Halt fetched, then redirect_valid=1, target=16'd5, one cycle later -> state RUN, halted never asserts, next valid if_pc=5.
- stall=1 and redirect_valid=1 in the same cycle, target=16'd9 -> pc=9, if_valid=0; with stall only, pc/if_* hold for every stalled cycle.
- Redirect to 16'hFFFF -> fetch 16'hFFFF, then pc=16'h0000; async rst_n pulse mid-HALT_PEND -> immediate pc=1, halted=0, if_valid=0.
